ex_issue_stage: RTL
===================

Name: ex_issue_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU.
- Latches one decoded RV32I integer instruction and maps opcode/funct3/funct7 to the 5-bit ALU operation code.
- Selects ALU operands (rs1, PC, zero, rs2, immediate, shamt) and resolves EX/MEM and MEM/WB forwarding at capture time.
- Presents a registered, valid/ready-handshaked operand bundle to the ALU inputs.

Parameters:
XLEN, 32, datapath width of operands and PC
OPW, 5, width of alu_op (ALU encoding: ADD=0 SUB=1 AND=2 OR=3 SLTU=4 XOR=5 SLL=6 SRL=7 SRA=8 SLT=9)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decode stage has an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  PC of instruction
in_instr  in  32  raw instruction word
in_rs1_data  in  XLEN  register-file read of rs1
in_rs2_data  in  XLEN  register-file read of rs2
in_imm  in  XLEN  sign-extended immediate (I or U form, produced by decoder)
fwd_exm_we  in  1  EX/MEM result will be written
fwd_exm_rd  in  5  EX/MEM destination
fwd_exm_data  in  XLEN  EX/MEM result
fwd_wb_we  in  1  MEM/WB result will be written
fwd_wb_rd  in  5  MEM/WB destination
fwd_wb_data  in  XLEN  MEM/WB result
flush  in  1  squash held and incoming instruction
out_valid  out  1  bundle valid to ALU
out_ready  in  1  downstream consumes bundle
alu_op  out  OPW  operation code for ALU
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_cin  out  1  ALU carry-in; always 0
rd  out  5  destination register
rd_we  out  1  result to be written back
illegal  out  1  instruction not an executable ALU op

Behaviour:
- Reset: out_valid, alu_op, alu_a, alu_b, alu_cin, rd, rd_we, illegal all 0. Reset asserted mid-operation discards the held bundle immediately (asynchronous).
- in_ready = !out_valid || out_ready. This is combinational; there is no bubble on back-to-back transfers.
- Capture: on the edge where in_valid && in_ready && !flush, all outputs load and out_valid becomes 1. Latency is 1 cycle.
- Consume: on an edge where out_ready && out_valid with no new capture, out_valid becomes 0.
- Stall: while out_valid && !out_ready, every output holds bit-stable.
- flush: has priority over capture and hold. Next edge gives out_valid=0 and no capture; data outputs may hold stale values.
- Forwarding for rs1 (instr[19:15]) and rs2 (instr[24:20]), evaluated at capture:
  - EX/MEM wins if fwd_exm_we and rd matches and rd!=0.
  - Otherwise MEM/WB if fwd_wb_we and rd matches and rd!=0.
  - Otherwise register-file data.
  - Source x0 always yields 0.
- Decode by opcode instr[6:0]:
  - 0110011 (R): a=rs1, b=rs2, rd_we=1.
  - 0010011 (I-ALU): a=rs1, b=imm, rd_we=1.
  - 0110111 (LUI): op=ADD, a=0, b=imm, rd_we=1.
  - 0010111 (AUIPC): op=ADD, a=in_pc, b=imm, rd_we=1.
  - Other opcodes: illegal=1, rd_we=0, op=ADD, a=b=0.
- funct3 map:
  - 000: ADD, or SUB when R and funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7=0100000.
  - 110: OR.
  - 111: AND.
  - I-type 000 ignores funct7.
- Shifts: alu_b = {27'b0, shamt}. shamt is rs2[4:0] for R, instr[24:20] for I.
- Illegal encodings (illegal=1, rd_we=0):
  - R funct7 other than 0000000/0100000.
  - R funct7=0100000 with funct3 not in {000,101}.
  - I shift with funct7 other than 0000000, or 0100000 for funct3 101 only.
- rd = instr[11:7]. rd_we forced 0 when rd=0.
- alu_cin is constant 0 in all cases.

Test Plan:
- Reset mid-stall: hold out_valid=1 with out_ready=0, pulse rst asynchronously -> outputs all 0 before the next clock edge, in_ready=1.
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=0, a=5, b=7, rd=3, rd_we=1, illegal=0.
- SUB x3,x1,x2 with fwd_exm (rd=1, data=100) and fwd_wb (rd=1, data=50) both active -> a=100 (EX/MEM wins), op=1. With rd=0 on both forwards and rs1 x0 -> a=0.
- SRAI x5,x4,3 with rs1=0x80000000 -> op=8, a=0x80000000, b=3. SLLI encoded with funct7=0100000 -> illegal=1, rd_we=0.
- AUIPC x1,0x12345 at pc=0x100 -> op=0, a=0x100, b=0x12345000. LUI x1 with the same immediate -> a=0.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; the next instruction is accepted in the same cycle out_ready rises. flush asserted with in_valid=1 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ex_issue_stage
// ID/EX pipeline register feeding the ALU. It captures one decoded RV32I
// integer instruction, maps opcode/funct3/funct7 to the ALU operation code,
// selects the two ALU operands, and resolves EX/MEM and MEM/WB forwarding
// when the instruction is captured. The bundle it presents is registered and
// moves on a valid/ready handshake.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_pc, in_instr          PC and raw instruction word
//   in_rs1_data, in_rs2_data register-file reads
//   in_imm                   sign-extended immediate from the decoder
//   fwd_exm_*                EX/MEM bypass (write enable, destination, data)
//   fwd_wb_*                 MEM/WB bypass (write enable, destination, data)
//   flush                    squashes the held and the incoming instruction
//   out_valid / out_ready    downstream handshake
//   alu_op, alu_a, alu_b     ALU operation and operands
//   alu_cin                  ALU carry-in (always 0)
//   rd, rd_we                destination register and write enable
//   illegal                  instruction is not an executable ALU op
module ex_issue_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            fwd_exm_we,
    input  logic [4:0]      fwd_exm_rd,
    input  logic [XLEN-1:0] fwd_exm_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            alu_cin,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [OPW-1:0] OP_ADD  = 5'd0;
    localparam logic [OPW-1:0] OP_SUB  = 5'd1;
    localparam logic [OPW-1:0] OP_AND  = 5'd2;
    localparam logic [OPW-1:0] OP_OR   = 5'd3;
    localparam logic [OPW-1:0] OP_SLTU = 5'd4;
    localparam logic [OPW-1:0] OP_XOR  = 5'd5;
    localparam logic [OPW-1:0] OP_SLL  = 5'd6;
    localparam logic [OPW-1:0] OP_SRL  = 5'd7;
    localparam logic [OPW-1:0] OP_SRA  = 5'd8;
    localparam logic [OPW-1:0] OP_SLT  = 5'd9;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Bypass priority: x0 is hard zero, then the younger EX/MEM result,
    // then the older MEM/WB result, then the register file.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_data,
        input logic            exm_we,
        input logic [4:0]      exm_rd,
        input logic [XLEN-1:0] exm_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] res;
        if (idx == 5'd0) begin
            res = '0;
        end else if (exm_we && (exm_rd == idx)) begin
            res = exm_data;
        end else if (wb_we && (wb_rd == idx)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Shift amounts reach the ALU zero-extended to the full operand width.
    function automatic logic [XLEN-1:0] shamt_ext(input logic [4:0] sh);
        return {{(XLEN-5){1'b0}}, sh};
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic            f7_zero_s;
    logic            f7_alt_s;
    logic [4:0]      rd_idx_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            in_ready_s;

    logic [OPW-1:0]  raw_op_s;
    logic [XLEN-1:0] raw_a_s;
    logic [XLEN-1:0] raw_b_s;
    logic            raw_we_s;
    logic            ill_s;

    logic [OPW-1:0]  nxt_op_s;
    logic [XLEN-1:0] nxt_a_s;
    logic [XLEN-1:0] nxt_b_s;
    logic            nxt_we_s;

    logic            valid_r;
    logic [OPW-1:0]  op_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic            cin_r;
    logic [4:0]      rd_r;
    logic            we_r;
    logic            ill_r;

    assign opcode_s  = in_instr[6:0];
    assign funct3_s  = in_instr[14:12];
    assign funct7_s  = in_instr[31:25];
    assign f7_zero_s = (funct7_s == 7'b0000000);
    assign f7_alt_s  = (funct7_s == 7'b0100000);
    assign rd_idx_s  = in_instr[11:7];

    assign rs1_val_s = fwd_sel(in_instr[19:15], in_rs1_data, fwd_exm_we, fwd_exm_rd,
                               fwd_exm_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    assign rs2_val_s = fwd_sel(in_instr[24:20], in_rs2_data, fwd_exm_we, fwd_exm_rd,
                               fwd_exm_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);

    // Opcode/funct decode into raw operation, operands and legality.
    always_comb begin
        raw_op_s = OP_ADD;
        raw_a_s  = '0;
        raw_b_s  = '0;
        raw_we_s = 1'b0;
        ill_s    = 1'b0;
        case (opcode_s)
            OPC_R: begin
                raw_a_s  = rs1_val_s;
                raw_b_s  = rs2_val_s;
                raw_we_s = 1'b1;
                // Only SUB and SRA use the alternate funct7.
                ill_s    = !(f7_zero_s ||
                             (f7_alt_s && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
                case (funct3_s)
                    3'b000: raw_op_s = f7_alt_s ? OP_SUB : OP_ADD;
                    3'b001: begin
                        raw_op_s = OP_SLL;
                        raw_b_s  = shamt_ext(rs2_val_s[4:0]);
                    end
                    3'b010: raw_op_s = OP_SLT;
                    3'b011: raw_op_s = OP_SLTU;
                    3'b100: raw_op_s = OP_XOR;
                    3'b101: begin
                        raw_op_s = f7_alt_s ? OP_SRA : OP_SRL;
                        raw_b_s  = shamt_ext(rs2_val_s[4:0]);
                    end
                    3'b110: raw_op_s = OP_OR;
                    default: raw_op_s = OP_AND;
                endcase
            end
            OPC_I: begin
                raw_a_s  = rs1_val_s;
                raw_b_s  = in_imm;
                raw_we_s = 1'b1;
                ill_s    = 1'b0;
                case (funct3_s)
                    3'b000: raw_op_s = OP_ADD;
                    3'b001: begin
                        raw_op_s = OP_SLL;
                        raw_b_s  = shamt_ext(in_instr[24:20]);
                        ill_s    = !f7_zero_s;
                    end
                    3'b010: raw_op_s = OP_SLT;
                    3'b011: raw_op_s = OP_SLTU;
                    3'b100: raw_op_s = OP_XOR;
                    3'b101: begin
                        raw_op_s = f7_alt_s ? OP_SRA : OP_SRL;
                        raw_b_s  = shamt_ext(in_instr[24:20]);
                        ill_s    = !(f7_zero_s || f7_alt_s);
                    end
                    3'b110: raw_op_s = OP_OR;
                    default: raw_op_s = OP_AND;
                endcase
            end
            OPC_LUI: begin
                raw_op_s = OP_ADD;
                raw_a_s  = '0;
                raw_b_s  = in_imm;
                raw_we_s = 1'b1;
            end
            OPC_AUIPC: begin
                raw_op_s = OP_ADD;
                raw_a_s  = in_pc;
                raw_b_s  = in_imm;
                raw_we_s = 1'b1;
            end
            default: begin
                ill_s = 1'b1;
            end
        endcase
    end

    // An illegal instruction is reduced to a harmless ADD 0,0 with no writeback,
    // and a write to x0 is never requested.
    assign nxt_op_s = ill_s ? OP_ADD : raw_op_s;
    assign nxt_a_s  = ill_s ? '0 : raw_a_s;
    assign nxt_b_s  = ill_s ? '0 : raw_b_s;
    assign nxt_we_s = raw_we_s && !ill_s && (rd_idx_s != 5'd0);

    assign in_ready_s = !valid_r || out_ready;

    // Output bundle register: flush squashes, handshake captures, consume drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            cin_r   <= 1'b0;
            rd_r    <= 5'd0;
            we_r    <= 1'b0;
            ill_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (in_valid && in_ready_s) begin
            valid_r <= 1'b1;
            op_r    <= nxt_op_s;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            cin_r   <= 1'b0;
            rd_r    <= rd_idx_s;
            we_r    <= nxt_we_s;
            ill_r   <= ill_s;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r;
    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_cin   = cin_r;
    assign rd        = rd_r;
    assign rd_we     = we_r;
    assign illegal   = ill_r;

endmodule
